// File: rtl/mem_read_arbiter.sv
// Arbitrates the shared memory read port between fetch and load, tracking the owner of each
// outstanding read in an in-order tag queue and routing returning data back to it.
module mem_read_arbiter #(
    parameter int unsigned ADDR_BITS       = 64,
    parameter int unsigned DATA_BITS       = 64,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       f_ren,
    input  logic [ADDR_BITS-1:0]                       f_raddr,
    input  logic                                       f_flush,
    output logic                                       f_gnt,
    output logic                                       f_rvalid,
    output logic [DATA_BITS-1:0]                       f_rdata,
    input  logic                                       l_ren,
    input  logic [ADDR_BITS-1:0]                       l_raddr,
    output logic                                       l_gnt,
    output logic                                       l_rvalid,
    output logic [DATA_BITS-1:0]                       l_rdata,
    output logic                                       mem_ren,
    output logic [ADDR_BITS-1:0]                       mem_raddr,
    input  logic                                       mem_rvalid,
    input  logic [DATA_BITS-1:0]                       mem_rdata,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding,
    output logic                                       protocol_err
);

    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

    // Tag queue storage: id 0 = fetch, id 1 = load.
    logic [MAX_OUTSTANDING-1:0] id_q, id_d;
    logic [MAX_OUTSTANDING-1:0] disc_q, disc_d;
    logic [PTR_W-1:0]           head_q, head_d;
    logic [PTR_W-1:0]           tail_q, tail_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [STV_W-1:0]           starve_q, starve_d;
    logic                       perr_q, perr_d;
    logic                       mem_ren_q, mem_ren_d;
    logic [ADDR_BITS-1:0]       mem_raddr_q, mem_raddr_d;

    logic not_full;
    logic starved;
    logic fetch_wins;
    logic push;
    logic pop;
    logic head_id;
    logic head_disc;

    assign not_full   = count_q < CNT_W'(MAX_OUTSTANDING);
    assign starved    = starve_q == STV_W'(STARVE_LIMIT);
    assign fetch_wins = f_ren && !f_flush && (!l_ren || starved);

    assign f_gnt = not_full && fetch_wins;
    assign l_gnt = not_full && l_ren && !fetch_wins;
    assign push  = f_gnt || l_gnt;
    assign pop   = mem_rvalid && (count_q != '0);

    assign head_id   = id_q[head_q];
    assign head_disc = disc_q[head_q];

    // A flush in the same cycle as a fetch pop suppresses that pop as well.
    assign f_rvalid     = pop && !head_id && !head_disc && !f_flush;
    assign l_rvalid     = pop && head_id;
    assign f_rdata      = mem_rdata;
    assign l_rdata      = mem_rdata;
    assign mem_ren      = mem_ren_q;
    assign mem_raddr    = mem_raddr_q;
    assign outstanding  = count_q;
    assign protocol_err = perr_q;

    always_comb begin
        id_d   = id_q;
        disc_d = disc_q;
        if (f_flush) begin
            disc_d = disc_q | ~id_q;
        end
        if (push) begin
            id_d[tail_q]   = l_gnt;
            disc_d[tail_q] = 1'b0;
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation counter is frozen while the queue is full since nobody can win then.
    always_comb begin
        starve_d = starve_q;
        if (not_full) begin
            if (f_gnt || !f_ren) begin
                starve_d = '0;
            end else if (!f_flush && l_gnt && !starved) begin
                starve_d = starve_q + STV_W'(1);
            end
        end
    end

    always_comb begin
        perr_d      = perr_q || (mem_rvalid && (count_q == '0));
        mem_ren_d   = push;
        mem_raddr_d = mem_raddr_q;
        if (f_gnt) begin
            mem_raddr_d = f_raddr;
        end else if (l_gnt) begin
            mem_raddr_d = l_raddr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q        <= '0;
            disc_q      <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            perr_q      <= 1'b0;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= '0;
        end else begin
            id_q        <= id_d;
            disc_q      <= disc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            perr_q      <= perr_d;
            mem_ren_q   <= mem_ren_d;
            mem_raddr_q <= mem_raddr_d;
        end
    end

endmodule

// File: doc/mem_read_arbiter.md
# mem_read_arbiter

Shares the single instruction/data memory read port between the fetch stage and the load unit. Arbitrates one read per cycle, registers the winning address onto the memory port, and tracks the requester of every outstanding read in an in-order tag queue. Returning data is routed to its owner. Fetch responses are silently discarded after a fetch flush (PC redirect). The block sits between the fetch/load requesters and the memory model.

## Interface
Parameters:
- ADDR_BITS, 64, read address width
- DATA_BITS, 64, read data width
- MAX_OUTSTANDING, 4, tag queue depth; power of two, ≥2
- STARVE_LIMIT, 4, consecutive lost fetch arbitrations before fetch is forced to win

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- f_ren  in  1  fetch read request; held until granted
- f_raddr  in  ADDR_BITS  fetch read address
- f_flush  in  1  fetch redirect; discard all outstanding fetch reads
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid (combinational)
- f_rdata  out  DATA_BITS  fetch read data
- l_ren  in  1  load read request; held until granted
- l_raddr  in  ADDR_BITS  load read address
- l_gnt  out  1  load request accepted this cycle (combinational)
- l_rvalid  out  1  load read data valid (combinational)
- l_rdata  out  DATA_BITS  load read data
- mem_ren  out  1  memory read enable (registered)
- mem_raddr  out  ADDR_BITS  memory read address (registered)
- mem_rvalid  in  1  memory read data valid; responses return in issue order
- mem_rdata  in  DATA_BITS  memory read data
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  occupancy of the tag queue
- protocol_err  out  1  sticky; set when mem_rvalid arrives while the queue is empty

## Operation
- Tag queue: circular FIFO of {id, discard}. id=0 is fetch, id=1 is load. Head and tail pointers wrap modulo MAX_OUTSTANDING. A separate count register drives `outstanding`.
- Grant is allowed only when count < MAX_OUTSTANDING. There is no same-cycle pop bypass, so a full queue blocks grants even while mem_rvalid pops an entry.
- Priority:
  - Load wins by default.
  - Fetch wins when only fetch requests, or when starve_cnt == STARVE_LIMIT.
- f_flush forces f_gnt=0 that cycle.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) when f_ren=1, not flushed, and fetch loses to load.
  - Clears on a fetch grant, or when f_ren=0.
  - Holds when the queue is full.
- On a grant:
  - mem_ren<=1 and mem_raddr<=winner address at the next edge.
  - Push {id, discard=0}.
  - With no grant, mem_ren<=0 and mem_raddr holds.
- On mem_rvalid with a non-empty queue:
  - Pop the head.
  - id=0 and discard=0: f_rvalid=1, f_rdata=mem_rdata.
  - id=1: l_rvalid=1, l_rdata=mem_rdata (unaffected by discard).
  - Discarded fetch entries pop with no output pulse.
- On mem_rvalid with an empty queue: no pop, no output; protocol_err<=1, cleared only by reset.
- f_flush sets discard on every queue entry with id=0, including an entry being popped in the same cycle. That popped entry is suppressed: f_rvalid=0.
- *_rdata equals mem_rdata at all times; only the valids are gated.

## Timing
- Request in cycle N with a grant: mem_ren high in cycle N+1. Total latency is 1 cycle plus the memory latency.
- Response path is combinational: f_rvalid/l_rvalid assert in the same cycle as mem_rvalid.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Reset (asynchronous, any time, including with reads outstanding):
  - mem_ren=0, mem_raddr=0, queue empty, count=0, starve_cnt=0, protocol_err=0.
  - Late responses for pre-reset reads set protocol_err.
- Single grant per cycle: f_gnt and l_gnt are never both 1.

## Test plan
- Fetch-only stream: f_ren=1 with addrs 0x08, 0x10, 0x18, memory latency 1, rdata=addr+0x100 → mem_raddr 0x08, 0x10, 0x18 on consecutive cycles; f_rvalid with 0x108, 0x110, 0x118; l_rvalid never asserts.
- Contention and starvation: f_ren and l_ren held high continuously, STARVE_LIMIT=4 → grant pattern L,L,L,L,F repeating; starve_cnt returns to 0 after each F.
- Full queue: memory stalls responses, 5 load requests, MAX_OUTSTANDING=4 → 4 grants, outstanding=4, 5th request waits; one mem_rvalid pops an entry, grant resumes on the following cycle.
- Flush: outstanding queue F,L,F, then f_flush, then 3 mem_rvalid pulses → only l_rvalid pulses (once); outstanding reaches 0.
- Spurious response: mem_rvalid=1 with queue empty → no rvalid output, protocol_err=1 and stays set.
- Async reset mid-traffic: rst_n low between edges with 2 reads outstanding → outputs reset immediately; after release, a new fetch of 0x40 completes normally.
